// File: rtl/ppa8_seq_adder_pkg.sv
// Shared types and constants for the byte-serial PPA8 add/subtract sequencer.
package ppa8_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 8;

    // Width of the byte index register for a given operand size in bytes.
    function automatic int idx_width(input int bytes);
        return (bytes > 2) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/ppa8_seq_adder_add8_slice.sv
// 8-bit Kogge-Stone parallel-prefix adder; carry-in folded into bit-0 generate.
module add8_slice
    import ppa8_seq_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] prop;
    logic [SLICE_W-1:0] gen_l [4];
    logic [SLICE_W-1:0] prp_l [4];
    logic [SLICE_W-1:0] carry_in;

    always_comb begin
        prop     = a ^ b;
        gen_l[0] = a & b;
        prp_l[0] = prop;
        gen_l[0][0] = gen_l[0][0] | (prop[0] & cin);
        for (int lvl = 1; lvl < 4; lvl++) begin
            for (int i = 0; i < SLICE_W; i++) begin
                if (i >= (1 << (lvl - 1))) begin
                    gen_l[lvl][i] = gen_l[lvl-1][i] |
                                    (prp_l[lvl-1][i] & gen_l[lvl-1][i - (1 << (lvl - 1))]);
                    prp_l[lvl][i] = prp_l[lvl-1][i] & prp_l[lvl-1][i - (1 << (lvl - 1))];
                end else begin
                    gen_l[lvl][i] = gen_l[lvl-1][i];
                    prp_l[lvl][i] = prp_l[lvl-1][i];
                end
            end
        end
        // gen_l[3][i] is the carry out of bit i including cin.
        carry_in = {gen_l[3][SLICE_W-2:0], cin};
        sum      = prop ^ carry_in;
        cout     = gen_l[3][SLICE_W-1];
    end

endmodule

// File: rtl/ppa8_seq_adder.sv
// Multi-precision add/subtract: issues one byte per cycle, LSB first, through a
// single add8_slice with the carry held in carry_q between bytes.
module ppa8_seq_adder
    import ppa8_seq_adder_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SLICE_W*BYTES-1:0]   req_a,
    input  logic [SLICE_W*BYTES-1:0]   req_b,
    input  logic                       req_cin,
    input  logic                       req_sub,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [SLICE_W*BYTES-1:0]   rsp_sum,
    output logic                       rsp_cout,
    output logic                       rsp_ovf,
    output logic                       busy
);

    localparam int W     = SLICE_W * BYTES;
    localparam int IDX_W = idx_width(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic               carry_q;
    logic               rdy_en_q;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;

    add8_slice u_slice (
        .a    (a_q[SLICE_W*int'(idx_q) +: SLICE_W]),
        .b    (b_q[SLICE_W*int'(idx_q) +: SLICE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign accept = (state_q == ST_IDLE) && rdy_en_q && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)            state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: if (rsp_ready)         state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = rdy_en_q;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract is A + ~B + 1, so the operand inversion and forced carry happen at load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= req_a;
            b_q     <= req_sub ? ~req_b : req_b;
            carry_q <= req_sub ? 1'b1 : req_cin;
            idx_q   <= '0;
        end else if (state_q == ST_RUN) begin
            sum_q[SLICE_W*int'(idx_q) +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
    end

    assign rsp_sum  = sum_q;
    assign rsp_cout = carry_q;
    assign rsp_ovf  = (a_q[W-1] == b_q[W-1]) & (sum_q[W-1] != a_q[W-1]);

endmodule
